// File: rtl/arith_traffic_gen.sv
// arith_traffic_gen
// Built-in self-test initiator for the registered 4-bit adder / 4-bit
// multiplier pair. It issues one operand set per cycle, controls the
// units' reset, checks their registered results one cycle later against
// internally computed expected values, and reports the outcome.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-low reset
//   start      one-cycle run request (honoured in IDLE or DONE only)
//   mode       0 = sweep, 1 = LFSR random; sampled with start
//   aa, ab     adder operands
//   ma, mb     multiplier operands
//   dut_rst    active-high reset to the adder/multiplier
//   aout       registered adder result (5 bits)
//   mout       registered multiplier result (8 bits)
//   busy       high while driving or draining
//   done       high in DONE, held until the next start
//   pass       valid with done; 1 iff no mismatches
//   err_count  number of failing transactions, saturating
//   fail_idx   index of the first failing transaction, 16'hFFFF if none
module arith_traffic_gen #(
  parameter int          NUM_TXN   = 256,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  output logic [3:0]  aa,
  output logic [3:0]  ab,
  output logic [3:0]  ma,
  output logic [3:0]  mb,
  output logic        dut_rst,
  input  logic [4:0]  aout,
  input  logic [7:0]  mout,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] fail_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_TXN - 1);

  // Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1 (right-shifting form).
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  state_t      state_r;
  logic [15:0] cur_idx_r;   // index of the transaction currently presented
  logic [15:0] lfsr_r;      // LFSR value for the next transaction
  logic        mode_r;

  // Stage 1: expected values aligned with the presented operands.
  logic        exp_valid_r;
  logic [4:0]  exp_a_r;
  logic [7:0]  exp_m_r;
  logic [15:0] exp_idx_r;

  // Stage 2: expected values aligned with the DUT's registered results.
  logic        chk_valid_r;
  logic [4:0]  chk_a_r;
  logic [7:0]  chk_m_r;
  logic [15:0] chk_idx_r;

  logic [15:0] gen_idx_s;
  logic [15:0] gen_lfsr_s;
  logic        gen_mode_s;
  logic [3:0]  gen_aa_s;
  logic [3:0]  gen_ab_s;
  logic [3:0]  gen_ma_s;
  logic [3:0]  gen_mb_s;
  logic [4:0]  gen_exp_a_s;
  logic [7:0]  gen_exp_m_s;

  logic        mismatch_s;
  logic [15:0] err_next_s;
  logic [15:0] fail_next_s;

  // Select the source of the next transaction: a fresh run starts from
  // index 0 / the seed / the mode input, otherwise continue the run.
  always_comb begin
    gen_idx_s  = 16'd0;
    gen_lfsr_s = LFSR_SEED;
    gen_mode_s = mode;
    if (state_r == S_DRIVE) begin
      gen_idx_s  = cur_idx_r + 16'd1;
      gen_lfsr_s = lfsr_r;
      gen_mode_s = mode_r;
    end else begin
      gen_idx_s  = 16'd0;
      gen_lfsr_s = LFSR_SEED;
      gen_mode_s = mode;
    end
  end

  // Operand generation and full-width expected results.
  always_comb begin
    gen_aa_s = 4'd0;
    gen_ab_s = 4'd0;
    gen_ma_s = 4'd0;
    gen_mb_s = 4'd0;
    if (gen_mode_s) begin
      gen_aa_s = gen_lfsr_s[3:0];
      gen_ab_s = gen_lfsr_s[7:4];
      gen_ma_s = gen_lfsr_s[11:8];
      gen_mb_s = gen_lfsr_s[15:12];
    end else begin
      gen_aa_s = gen_idx_s[3:0];
      gen_ab_s = gen_idx_s[7:4];
      gen_ma_s = gen_idx_s[3:0];
      gen_mb_s = gen_idx_s[7:4];
    end
    gen_exp_a_s = {1'b0, gen_aa_s} + {1'b0, gen_ab_s};
    gen_exp_m_s = {4'd0, gen_ma_s} * {4'd0, gen_mb_s};
  end

  // Result comparison and next error bookkeeping; err_count==0 marks
  // that no earlier failure has been recorded in this run.
  always_comb begin
    mismatch_s  = chk_valid_r && ((aout != chk_a_r) || (mout != chk_m_r));
    err_next_s  = err_count;
    fail_next_s = fail_idx;
    if (mismatch_s) begin
      if (err_count != 16'hFFFF) begin
        err_next_s = err_count + 16'd1;
      end else begin
        err_next_s = err_count;
      end
      if (err_count == 16'd0) begin
        fail_next_s = chk_idx_r;
      end else begin
        fail_next_s = fail_idx;
      end
    end else begin
      err_next_s  = err_count;
      fail_next_s = fail_idx;
    end
  end

  // Control FSM with registered operands, expected pipeline and status.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      cur_idx_r   <= 16'd0;
      lfsr_r      <= LFSR_SEED;
      mode_r      <= 1'b0;
      exp_valid_r <= 1'b0;
      exp_a_r     <= 5'd0;
      exp_m_r     <= 8'd0;
      exp_idx_r   <= 16'd0;
      chk_valid_r <= 1'b0;
      chk_a_r     <= 5'd0;
      chk_m_r     <= 8'd0;
      chk_idx_r   <= 16'd0;
      aa          <= 4'd0;
      ab          <= 4'd0;
      ma          <= 4'd0;
      mb          <= 4'd0;
      dut_rst     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= 16'd0;
      fail_idx    <= 16'hFFFF;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_r     <= S_DRIVE;
            cur_idx_r   <= 16'd0;
            lfsr_r      <= lfsr_next(LFSR_SEED);
            mode_r      <= mode;
            aa          <= gen_aa_s;
            ab          <= gen_ab_s;
            ma          <= gen_ma_s;
            mb          <= gen_mb_s;
            exp_valid_r <= 1'b1;
            exp_a_r     <= gen_exp_a_s;
            exp_m_r     <= gen_exp_m_s;
            exp_idx_r   <= 16'd0;
            chk_valid_r <= 1'b0;
            dut_rst     <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= 16'd0;
            fail_idx    <= 16'hFFFF;
          end
        end
        S_DRIVE: begin
          err_count   <= err_next_s;
          fail_idx    <= fail_next_s;
          chk_valid_r <= exp_valid_r;
          chk_a_r     <= exp_a_r;
          chk_m_r     <= exp_m_r;
          chk_idx_r   <= exp_idx_r;
          if (cur_idx_r == LAST_IDX) begin
            state_r     <= S_DRAIN;
            exp_valid_r <= 1'b0;
          end else begin
            cur_idx_r   <= gen_idx_s;
            lfsr_r      <= lfsr_next(lfsr_r);
            aa          <= gen_aa_s;
            ab          <= gen_ab_s;
            ma          <= gen_ma_s;
            mb          <= gen_mb_s;
            exp_valid_r <= 1'b1;
            exp_a_r     <= gen_exp_a_s;
            exp_m_r     <= gen_exp_m_s;
            exp_idx_r   <= gen_idx_s;
          end
        end
        S_DRAIN: begin
          // Final compare lands here; pass must include its outcome.
          err_count   <= err_next_s;
          fail_idx    <= fail_next_s;
          chk_valid_r <= 1'b0;
          state_r     <= S_DONE;
          dut_rst     <= 1'b1;
          busy        <= 1'b0;
          done        <= 1'b1;
          pass        <= (err_next_s == 16'd0);
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/arith_traffic_gen.md
Name: arith_traffic_gen

Overview:
- Self-checking initiator for the registered 4-bit adder and 4-bit multiplier datapath. It is the driving end of their operand/result interface.
- Issues one operand set per cycle to both units and controls their reset.
- Samples the registered results one cycle later and compares them against internally computed expected values.
- Reports pass/fail, an error count and the first failing transaction index. Sits beside the arithmetic top as a built-in self-test engine.

Parameters:
- NUM_TXN, 256, transactions per run (1..65535).
- LFSR_SEED, 16'hACE1, nonzero seed loaded into the LFSR on each start.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle run request; honoured only in IDLE or DONE.
- mode  in  1  0 = sweep, 1 = LFSR random; sampled with start.
- aa, ab  out  4 each  adder operands.
- ma, mb  out  4 each  multiplier operands.
- dut_rst  out  1  active-high reset to the adder/multiplier.
- aout  in  5  registered adder result.
- mout  in  8  registered multiplier result.
- busy  out  1  high in DRIVE and DRAIN.
- done  out  1  high in DONE; held until next start.
- pass  out  1  valid when done; 1 iff err_count == 0.
- err_count  out  16  mismatching transactions, saturating at 16'hFFFF.
- fail_idx  out  16  index of first mismatch; 16'hFFFF if none.

Behaviour:
- Reset (rst=0 at clk edge):
  - State goes to IDLE.
  - aa=ab=ma=mb=0, dut_rst=1, busy=0, done=0, pass=0, err_count=0, fail_idx=16'hFFFF.
  - LFSR loads LFSR_SEED; issue and check counters clear.
  - Reset mid-run aborts immediately; no partial result is retained.
- All outputs are registered.
- FSM states: IDLE, DRIVE, DRAIN, DONE.
  - IDLE/DONE + start -> DRIVE. Clear err_count and counters, set fail_idx=FFFF, latch mode, load LFSR_SEED, drop dut_rst to 0, present transaction 0.
  - DRIVE: one new operand set every cycle. After transaction NUM_TXN-1 is presented -> DRAIN.
  - DRAIN: lasts exactly one cycle to check the final result, then -> DONE.
  - DONE: dut_rst=1, done=1, pass = (err_count==0).
- start is ignored while busy. start in DONE begins a fresh run.
- Operand generation for transaction index i:
  - Sweep: aa=ma=i[3:0], ab=mb=i[7:4]. The pattern wraps every 256 transactions.
  - LFSR: aa=L[3:0], ab=L[7:4], ma=L[11:8], mb=L[15:12], where L is the current LFSR value.
  - LFSR is a Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1. It shifts once per issued transaction after use.
- Expected-value pipeline, registered alongside the operands:
  - exp_a = aa+ab, full 5-bit, no truncation.
  - exp_m = ma*mb, full 8-bit.
  - A valid bit travels with them.
- Latency: operands presented in cycle t are captured by the DUT at the end of t. aout/mout are compared in cycle t+1. The first compare happens in the cycle after the first DRIVE cycle.
- Compare: a transaction fails if aout!=exp_a or mout!=exp_m. Either or both mismatching count as one error.
  - On the first failure, fail_idx = that transaction index.
  - err_count increments by 1 per failing transaction and holds at FFFF.
- NUM_TXN=1: one DRIVE cycle, one DRAIN cycle, then DONE.
- Operands hold their last values in DRAIN/DONE. dut_rst=1 forces DUT outputs to 0; no compares happen in IDLE/DONE.

Test Plan:
- Sweep mode, NUM_TXN=256, correct DUT -> busy for 257 cycles, then done=1, pass=1, err_count=0, fail_idx=FFFF. Txn 255 drives aa=ab=15 and expects aout=30, mout=225.
- LFSR mode, seed ACE1 -> first operands aa=1, ab=E, ma=C, mb=A; next cycle expects aout=5'h0F, mout=8'h78; LFSR steps to 5670.
- Sweep run with bench forcing aout[0] inverted on transactions 3 and 7 -> err_count=2, fail_idx=3, pass=0.
- NUM_TXN=1 -> DRIVE 1 cycle, DRAIN 1 cycle, done asserted on the 3rd cycle after start.
- start pulsed again in mid-run -> ignored; run completes with identical counts. start in DONE -> counters clear and a new run begins.
- rst=0 in mid-run -> next cycle IDLE, dut_rst=1, busy=0, done=0, err_count=0, fail_idx=FFFF.
